// File: rtl/pipelined_left_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pipelined_left_shifter
//  Description : Five-stage pipelined 32-bit left barrel shifter. It performs
//                either a logical shift left (zero fill) or a rotate left.
//                Stage k resolves shift-amount bit k, starting from the LSB.
//                A valid/ready handshake with a global stall lets the unit
//                sit directly in a backpressured execute pipe.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                in_valid  - operand valid
//                in_ready  - pipeline accepts an operand this cycle
//                a         - operand
//                sel       - shift amount, 0..WIDTH-1
//                rotate    - 1 = rotate left, 0 = logical shift left
//                out_valid - b holds a valid result
//                out_ready - consumer takes b this cycle
//                b         - result
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_left_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   sel,
    input  logic             rotate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b
);

    // Per-stage inputs (w_*_in), per-stage combinational results (w_dout)
    // and per-stage registers (r_*). Index k is the stage number.
    logic [SHW-1:0][WIDTH-1:0] w_din;
    logic [SHW-1:0][WIDTH-1:0] w_dout;
    logic [SHW-1:0][SHW-1:0]   w_sel_in;
    logic [SHW-1:0]            w_rot_in;
    logic [SHW-1:0]            w_vld_in;

    logic [SHW-1:0][WIDTH-1:0] r_data;
    logic [SHW-1:0][SHW-1:0]   r_sel;
    logic [SHW-1:0]            r_rot;
    logic [SHW-1:0]            r_vld;

    logic                      w_adv;

    // The whole pipe moves as one: it advances whenever the output slot is
    // empty or is being drained this cycle.
    assign w_adv     = out_ready | ~r_vld[SHW-1];
    assign in_ready  = w_adv;
    assign out_valid = r_vld[SHW-1];
    assign b         = r_data[SHW-1];

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            localparam int c_shamt = 1 << k;

            if (k == 0) begin : g_head
                assign w_din[k]    = a;
                assign w_sel_in[k] = sel;
                assign w_rot_in[k] = rotate;
                assign w_vld_in[k] = in_valid;
            end else begin : g_link
                assign w_din[k]    = r_data[k-1];
                assign w_sel_in[k] = r_sel[k-1];
                assign w_rot_in[k] = r_rot[k-1];
                assign w_vld_in[k] = r_vld[k-1];
            end

            // One 2:1 select per bit. Low bits vacated by the shift take the
            // bits that fall off the top when rotating, zero otherwise.
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= c_shamt) begin : g_mid
                    assign w_dout[k][i] = w_sel_in[k][k] ? w_din[k][i-c_shamt]
                                                         : w_din[k][i];
                end else begin : g_wrap
                    assign w_dout[k][i] = w_sel_in[k][k]
                                        ? (w_rot_in[k] & w_din[k][WIDTH-c_shamt+i])
                                        : w_din[k][i];
                end
            end
        end
    endgenerate

    // Data of bubble stages moves along with the valid bits; only the valid
    // bits carry meaning, so no per-stage enable is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= '0;
            r_rot  <= '0;
            r_vld  <= '0;
        end else if (w_adv) begin
            r_data <= w_dout;
            r_sel  <= w_sel_in;
            r_rot  <= w_rot_in;
            r_vld  <= w_vld_in;
        end
    end

    // The last stage's shift-control copies have no consumer downstream.
    logic w_unused_tail;
    assign w_unused_tail = ^{r_sel[SHW-1], r_rot[SHW-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_left_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipelined_left_shifter
//  Description : Self-checking bench for pipelined_left_shifter. Directed
//                vectors with hand-computed results, a stall window, an
//                asynchronous reset pulse with operands in flight, and a
//                random handshake regression checked against a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_left_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   sel;
    logic             rotate;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [WIDTH-1:0] sb_q[$];

    logic [WIDTH-1:0] d_a[8];
    logic [SHW-1:0]   d_sel[8];
    logic             d_rot[8];
    logic [WIDTH-1:0] d_exp[8];
    int               d_n;

    always #5 clk = ~clk;

    pipelined_left_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sel       (sel),
        .rotate    (rotate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [SHW-1:0] s,
                                               input logic r);
        int sh;
        sh = int'(s);
        if (sh == 0) return x;
        if (r) return (x << sh) | (x >> (WIDTH - sh));
        return x << sh;
    endfunction

    // Scoreboard: at the falling edge the handshakes that the next rising
    // edge will complete are stable; consume before accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                pops++;
                if (sb_q.size() == 0)
                    check("sb_unexpected_result", 32'(out_valid), 32'd0);
                else
                    check("sb_order", b, sb_q.pop_front());
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(a, sel, rotate));
        end
    end

    // Sends d_n operands back-to-back into an empty pipe with out_ready=1.
    // Operand i is presented in cycle i and must show on b in cycle i+5.
    task automatic run_directed(input string tag);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < d_n + 6; cyc++) begin
            if (cyc < d_n) begin
                in_valid = 1'b1;
                a        = d_a[cyc];
                sel      = d_sel[cyc];
                rotate   = d_rot[cyc];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 5 && cyc - 5 < d_n) begin
                check({tag, "_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_b"}, b, d_exp[cyc-5]);
            end else begin
                check({tag, "_idle"}, 32'(out_valid), 32'd0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stall_test();
        logic [WIDTH-1:0] sa[8];
        logic [SHW-1:0]   ss[8];
        logic             sr[8];
        int               idx;
        int               p0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom;
            ss[i] = 5'($urandom_range(0, 31));
            sr[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        p0  = pops;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 10);
            if (idx < 8) begin
                in_valid = 1'b1;
                a        = sa[idx];
                sel      = ss[idx];
                rotate   = sr[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 6 && cyc <= 10) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_b_held", b, model(sa[1], ss[1], sr[1]));
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        check("stall_accepted", 32'(idx), 32'd8);
        check("stall_results", 32'(pops - p0), 32'd8);
    endtask

    task automatic reset_test();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = (cyc < 3);
            a        = (cyc == 0) ? 32'hDEADBEEF : 32'h0BAD_F00D + 32'(cyc);
            sel      = (cyc == 0) ? 5'd4 : 5'd7;
            rotate   = 1'b1;
            @(negedge clk);
            if (cyc == 5) begin
                check("rst_pre_valid", 32'(out_valid), 32'd1);
                check("rst_pre_b", b, 32'hEADBEEFD);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_b", b, 32'd0);
        check("rst_async_in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        d_n = 1;
        d_a[0] = 32'h0000F00D; d_sel[0] = 5'd12; d_rot[0] = 1'b0; d_exp[0] = 32'h0F00D000;
        run_directed("rst_first");
    endtask

    task automatic random_test();
        int   acc;
        int   cyc;
        int   p0;
        logic pending;
        acc     = 0;
        cyc     = 0;
        p0      = pops;
        pending = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = $urandom;
                sel      = 5'($urandom_range(0, 31));
                rotate   = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc++;
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_accepted", 32'(acc), 32'd10000);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("rand_drain_left", 32'(sb_q.size()), 32'd0);
        check("rand_results", 32'(pops - p0), 32'(acc));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        sel       = '0;
        rotate    = 1'b0;
        out_ready = 1'b0;

        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_b", b, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        d_n = 1;
        d_a[0] = 32'h00000001; d_sel[0] = 5'd31; d_rot[0] = 1'b0; d_exp[0] = 32'h80000000;
        run_directed("sel31_shl");

        d_n = 3;
        d_a[0] = 32'h80000001; d_sel[0] = 5'd1; d_rot[0] = 1'b1; d_exp[0] = 32'h00000003;
        d_a[1] = 32'h80000001; d_sel[1] = 5'd1; d_rot[1] = 1'b0; d_exp[1] = 32'h00000002;
        d_a[2] = 32'h80000001; d_sel[2] = 5'd0; d_rot[2] = 1'b1; d_exp[2] = 32'h80000001;
        run_directed("msb_lsb");

        d_n = 3;
        d_a[0] = 32'h12345678; d_sel[0] = 5'd8;  d_rot[0] = 1'b1; d_exp[0] = 32'h34567812;
        d_a[1] = 32'h12345678; d_sel[1] = 5'd16; d_rot[1] = 1'b0; d_exp[1] = 32'h56780000;
        d_a[2] = 32'h12345678; d_sel[2] = 5'd20; d_rot[2] = 1'b1; d_exp[2] = 32'h67812345;
        run_directed("b2b");

        stall_test();
        reset_test();
        random_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_left_shifter.md
Name: pipelined_left_shifter

Overview:
- 5-stage pipelined barrel shifter for 32-bit data that performs logical left shift (zero fill) or left rotate.
- It is the left-direction counterpart of the team's pipelined right shift/rotate unit. Together the two give the datapath both shift directions with the same latency.
- One shift-amount bit is resolved per stage, LSB first. Each stage registers its result.
- Unlike the right-shift unit, it carries a valid/ready handshake with global stall so it can sit directly in a backpressured execute pipe.

Parameters:
- WIDTH, 32, data width. Must be a power of two.
- SHW, 5, shift-amount width. Equals log2(WIDTH) and is also the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operand valid
- in_ready  output  1  pipeline can accept an operand this cycle
- a  input  WIDTH  operand
- sel  input  SHW  shift amount, 0..31
- rotate  input  1  1 = rotate left (bits leaving MSB re-enter at LSB); 0 = logical shift left (zero fill)
- out_valid  output  1  b holds a valid result
- out_ready  input  1  consumer accepts b this cycle
- b  output  WIDTH  result

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
  - While rst_n=0, every stage valid bit, data register, sel copy and rotate copy clears to 0 immediately, without waiting for a clock edge.
  - Therefore out_valid=0 and b=0 during reset. in_ready=1 during reset.
  - Deasserting reset mid-stream discards all in-flight operands; none reappear.
- Stage k (k=0..4) behaviour:
  - If the stage's sel copy bit k is 1, it shifts its input left by 2^k. Otherwise it passes the input through.
  - Vacated low bits take the top 2^k input bits when its rotate copy is 1, else 0.
  - Stage 0 takes a, sel and rotate directly.
  - Each stage registers its data, the remaining sel bits, rotate and a valid bit.
  - Stage 4's registers drive b and out_valid.
- Advance condition: adv = out_ready | ~out_valid. in_ready = adv (combinational).
- When adv=1 on a clock edge:
  - All stage registers load from their predecessor.
  - Stage 0 valid loads in_valid; bubbles propagate as valid=0.
- When adv=0: every stage register holds, including b and out_valid.
- Once out_valid=1, b is stable until the cycle in which out_ready=1.
- Latency: with no stall, a result appears on b exactly 5 cycles after the acceptance edge (in_valid & in_ready). Throughput is 1 operand per cycle.
- Transfer rules:
  - A result is consumed on a cycle with out_valid & out_ready.
  - An operand is accepted on a cycle with in_valid & in_ready.
  - Accept and consume in the same cycle are legal.
- Ordering: results leave strictly in input order. No loss and no duplication under any stall pattern.
- Data for invalid stages still moves on adv. b is don't-care while out_valid=0, except after reset, when it is 0.
- Boundary cases:
  - sel=0 gives b=a.
  - sel=31 with rotate=0 leaves only a[0], in bit 31.
  - A rotate by any sel equals a rotated left by sel mod 32.
- Implementation is flat per stage: no multiplier, no variable-index shifter. It is an explicit 2:1 select per bit per stage.

Test Plan:
- a=0x00000001, sel=31, rotate=0, out_ready=1 → b=0x80000000, out_valid=1 exactly 5 cycles after acceptance, for 1 cycle.
- a=0x80000001, sel=1 → rotate=1 gives b=0x00000003; rotate=0 gives b=0x00000002. Same operand with sel=0 gives b=0x80000001.
- a=0x12345678 → sel=8, rotate=1 gives 0x34567812; sel=16, rotate=0 gives 0x56780000; sel=20, rotate=1 gives 0x67812345. Sent back-to-back, results emerge on 3 consecutive cycles in order.
- Stream 8 random operands with out_ready=0 from cycle 6 to 10:
  - During the stall, in_ready=0 and b/out_valid are held.
  - After release, all 8 results emerge in order, each matching the reference model ((a<<s) or rotl(a,s)), with none lost or duplicated.
- Pulse rst_n=0 asynchronously (between edges) while 3 operands are in flight → out_valid and b go to 0 immediately. No stale result appears after rst_n=1. The first new operand returns after 5 cycles.
- Random regression of 10k operands with random in_valid/out_ready toggling → scoreboard matches the model for both rotate values and all 32 shift amounts.
